// File: rtl/dcache_2way_top_if.sv
// CPU load/store port and line-wide memory port of the two-way L1 data cache.
// slave = cache side, master = environment (CPU + memory) side.
`timescale 1ns/1ps
interface dcache_2way_top_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [31:0]       p1_data_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;

  modport slave (
    input  p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
  modport master (
    output p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_2way_top.sv
// Two-way set-associative write-back / write-allocate L1 data cache with true LRU,
// combinational lookup and a stall-until-resolved WB -> GAP -> FILL miss engine.
`timescale 1ns/1ps
module dcache_2way_top #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_2way_top_if.slave   bus
);
  localparam int LINE_W = 8*LINE_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W-IDX_W-OFF_W;
  localparam int WSEL_W = OFF_W-2;
  localparam int LA_W   = ADDR_W-OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_GAP, S_FILL} state_t;

  logic [1:0][SETS-1:0]              valid_q, dirty_q;
  logic [SETS-1:0]                   lru_q;
  logic [1:0][SETS-1:0][TAG_W-1:0]   tag_q;
  logic [1:0][SETS-1:0][LINE_W-1:0]  data_q;

  state_t            state_q, state_d;
  logic              vic_q, vic_d;
  logic [LA_W-1:0]   mline_q, mline_d;
  logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic              req, hit, hit_way, miss, wr_hit, vic, fill_done;
  logic [1:0]        hit_w;
  logic [IDX_W-1:0]  idx, midx, d_idx;
  logic [TAG_W-1:0]  tag, mtag;
  logic [WSEL_W-1:0] wsel;
  logic [LINE_W-1:0] hit_line;
  logic              unused_addr;

  assign req         = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign idx         = bus.p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag         = bus.p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign wsel        = bus.p1_addr_i[OFF_W-1:2];
  assign unused_addr = ^bus.p1_addr_i[1:0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit_w[w] = req && valid_q[w][idx] && (tag_q[w][idx] == tag);
  end

  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  assign miss     = req && !hit;
  assign wr_hit   = hit && bus.p1_MemWrite_i;
  assign hit_line = data_q[hit_way][idx];

  assign bus.p1_stall_o = miss;
  assign bus.p1_data_o  = (hit && !bus.p1_MemWrite_i) ? hit_line[{wsel, 5'b0} +: 32] : 32'h0;

  // Invalid ways are consumed first; only a full set falls back to LRU.
  assign vic       = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign midx      = mline_q[IDX_W-1:0];
  assign mtag      = mline_q[LA_W-1:IDX_W];
  assign fill_done = (state_q == S_FILL) && bus.mem_ack_i;

  always_comb begin
    state_d = state_q;
    vic_d   = vic_q;
    mline_d = mline_q;
    case (state_q)
      S_IDLE: if (miss) begin
        vic_d   = vic;
        mline_d = {tag, idx};
        state_d = (valid_q[vic][idx] && dirty_q[vic][idx]) ? S_WB : S_FILL;
      end
      S_WB:    if (bus.mem_ack_i) state_d = S_GAP;
      S_GAP:   state_d = S_FILL;
      S_FILL:  if (bus.mem_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port is registered off the next state so it lines up with the FSM.
  assign d_idx = mline_d[IDX_W-1:0];
  always_comb begin
    mem_en_d   = (state_d == S_WB) || (state_d == S_FILL);
    mem_wr_d   = (state_d == S_WB);
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (state_d == S_WB) begin
      mem_addr_d = {tag_q[vic_d][d_idx], d_idx, {OFF_W{1'b0}}};
      mem_data_d = data_q[vic_d][d_idx];
    end else if (state_d == S_FILL) begin
      mem_addr_d = {mline_d, {OFF_W{1'b0}}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      vic_q      <= 1'b0;
      mline_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      vic_q      <= vic_d;
      mline_q    <= mline_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (fill_done) begin
        valid_q[vic_q][midx] <= 1'b1;
        dirty_q[vic_q][midx] <= 1'b0;
        lru_q[midx]          <= ~vic_q;
      end else if (hit) begin
        lru_q[idx] <= ~hit_way;
        if (bus.p1_MemWrite_i) dirty_q[hit_way][idx] <= 1'b1;
      end
    end
  end

  // Payload arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[vic_q][midx] <= bus.mem_data_i;
      tag_q[vic_q][midx]  <= mtag;
    end else if (wr_hit) begin
      data_q[hit_way][idx][{wsel, 5'b0} +: 32] <= bus.p1_data_i;
    end
  end

  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed vectors for dcache_2way_top against a fixed-latency line memory model.
`timescale 1ns/1ps
module tb_dcache_2way_top;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_2way_top_if #(.ADDR_W(32), .LINE_W(256)) bus();
  dcache_2way_top #(.ADDR_W(32), .LINE_BYTES(32), .SETS(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           rise;
    int           ack;
  } txn_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rd;
    bit          exp_wb;
    logic [31:0] wb_addr;
    int          wb_word;
    logic [31:0] wb_val;
    logic [31:0] fill_addr;
  } vec_t;

  txn_t         log_q[$];
  logic [255:0] mem [logic [31:0]];
  int           cnt = 0, rise_cyc = 0;
  bit           prev_en = 1'b0;
  int           nvec = 0, nmis = 0;

  function automatic logic [255:0] dflt(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (a + 32'(4*k)) ^ 32'h5A5A0000;
    return l;
  endfunction

  function automatic logic [255:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  initial begin
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
  end

  // Memory: ack is a one-cycle pulse in the (L+1)-th cycle that enable is high.
  always @(negedge clk) begin
    txn_t t;
    if (bus.mem_ack_i) begin
      bus.mem_ack_i = 1'b0;
      cnt = 0;
    end else if (bus.mem_enable_o) begin
      if (!prev_en) rise_cyc = cyc;
      cnt++;
      if (cnt == L+1) begin
        t.wr = bus.mem_write_o; t.addr = bus.mem_addr_o; t.rise = rise_cyc; t.ack = cyc;
        if (bus.mem_write_o) begin
          t.data = bus.mem_data_o;
          mem[bus.mem_addr_o] = bus.mem_data_o;
        end else begin
          t.data = mem_rd(bus.mem_addr_o);
          bus.mem_data_i = t.data;
        end
        log_q.push_back(t);
        bus.mem_ack_i = 1'b1;
      end
    end else begin
      cnt = 0;
    end
    prev_en = bus.mem_enable_o;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic p1_idle();
    bus.p1_MemRead_i = 1'b0; bus.p1_MemWrite_i = 1'b0;
    bus.p1_addr_i = '0; bus.p1_data_i = '0;
  endtask

  // Called at a negedge; returns at a negedge after the access has committed.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int nst, output logic [31:0] rd, output int start);
    log_q.delete();
    start = cyc;
    bus.p1_addr_i = a; bus.p1_data_i = d;
    bus.p1_MemWrite_i = we; bus.p1_MemRead_i = !we;
    nst = 0;
    #1;
    while (bus.p1_stall_o && nst < 200) begin
      @(negedge clk); #1; nst++;
    end
    rd = bus.p1_data_o;
    @(negedge clk);
    p1_idle();
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    int nst, start, ntx;
    logic [31:0] rd;
    txn_t f, w;
    access(v.we, v.addr, v.wdata, nst, rd, start);
    chk($sformatf("v%0d stall_cycles", n), nst, v.exp_stall);
    if (!v.we) chk($sformatf("v%0d p1_data_o", n), rd, v.exp_rd);
    ntx = (v.exp_stall == 0) ? 0 : (v.exp_wb ? 2 : 1);
    chk($sformatf("v%0d mem_txns", n), log_q.size(), ntx);
    if (ntx != 0 && log_q.size() == ntx) begin
      f = log_q[ntx-1];
      chk($sformatf("v%0d fill_write", n), f.wr, 0);
      chk($sformatf("v%0d fill_addr", n), f.addr, v.fill_addr);
      chk($sformatf("v%0d fill_start", n), f.rise - start, v.exp_wb ? 3+L : 1);
      if (v.exp_wb) begin
        w = log_q[0];
        chk($sformatf("v%0d wb_write", n), w.wr, 1);
        chk($sformatf("v%0d wb_addr", n), w.addr, v.wb_addr);
        chk($sformatf("v%0d wb_word", n), w.data[v.wb_word*32 +: 32], v.wb_val);
        chk($sformatf("v%0d gap", n), f.rise - w.ack, 2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    vec_t post [2];
    logic [255:0] l0;
    int k;

    // we, addr, wdata, stall, rd, wb, wb_addr, wb_word, wb_val, fill_addr
    tbl[0]  = '{1'b0, 32'h0000_0004, 32'h0, 5,  32'hDEADBEEF, 1'b0, 32'h0, 0, 32'h0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h0000_0200, 32'h0, 5,  32'h5A5A0200, 1'b0, 32'h0, 0, 32'h0, 32'h0000_0200};
    tbl[2]  = '{1'b0, 32'h0000_0000, 32'h0, 0,  32'h5A5A0000, 1'b0, 32'h0, 0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_0204, 32'h0, 0,  32'h5A5A0204, 1'b0, 32'h0, 0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 32'h0000_0008, 32'h11111111, 0, 32'h0, 1'b0, 32'h0, 0, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0200, 32'h0, 0,  32'h5A5A0200, 1'b0, 32'h0, 0, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0400, 32'h0, 10, 32'h5A5A0400, 1'b1, 32'h0000_0000, 2, 32'h11111111, 32'h0000_0400};
    tbl[7]  = '{1'b0, 32'h0000_0008, 32'h0, 5,  32'h11111111, 1'b0, 32'h0, 0, 32'h0, 32'h0000_0000};
    tbl[8]  = '{1'b1, 32'h0000_1004, 32'hA5A5A5A5, 5, 32'h0, 1'b0, 32'h0, 0, 32'h0, 32'h0000_1000};
    tbl[9]  = '{1'b0, 32'h0000_1004, 32'h0, 0,  32'hA5A5A5A5, 1'b0, 32'h0, 0, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_0004, 32'h0, 0,  32'hDEADBEEF, 1'b0, 32'h0, 0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_0600, 32'h0, 10, 32'h5A5A0600, 1'b1, 32'h0000_1000, 1, 32'hA5A5A5A5, 32'h0000_0600};
    tbl[12] = '{1'b0, 32'h0000_0024, 32'h0, 5,  32'h5A5A0024, 1'b0, 32'h0, 0, 32'h0, 32'h0000_0020};
    tbl[13] = '{1'b0, 32'h0000_1004, 32'h0, 5,  32'hA5A5A5A5, 1'b0, 32'h0, 0, 32'h0, 32'h0000_1000};
    post[0] = '{1'b0, 32'h0000_0024, 32'h0, 5,  32'h5A5A0024, 1'b0, 32'h0, 0, 32'h0, 32'h0000_0020};
    post[1] = '{1'b0, 32'h0000_0008, 32'h0, 5,  32'h11111111, 1'b0, 32'h0, 0, 32'h0, 32'h0000_0000};

    l0 = dflt(32'h0);
    l0[63:32] = 32'hDEADBEEF;
    mem[32'h0] = l0;

    p1_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst mem_enable_o", bus.mem_enable_o, 0);
    chk("rst mem_write_o", bus.mem_write_o, 0);
    chk("rst mem_addr_o", bus.mem_addr_o, 0);
    chk("rst mem_data_o", bus.mem_data_o, 0);
    chk("rst p1_stall_o", bus.p1_stall_o, 0);
    chk("rst p1_data_o", bus.p1_data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) apply_vec(tbl[i], i);

    // Reset while a fill is outstanding.
    bus.p1_addr_i = 32'h0000_2004; bus.p1_MemRead_i = 1'b1;
    k = 0;
    while (!bus.mem_enable_o && k < 20) begin
      @(negedge clk); k++;
    end
    chk("midfill enable_seen", bus.mem_enable_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill enable_drop", bus.mem_enable_o, 0);
    chk("midfill addr_clear", bus.mem_addr_o, 0);
    p1_idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst p1_stall_o", bus.p1_stall_o, 0);
    chk("postrst p1_data_o", bus.p1_data_o, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) apply_vec(post[i], 20 + i);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/dcache_2way_top.md
# dcache_2way_top

Two-way set-associative, write-back, write-allocate L1 data cache, parametrised in set count and line size. It sits between the CPU load/store port (p1_*) and the line-wide data memory (mem_*). It replaces the direct-mapped data cache with true-LRU replacement, invalid-way-first victim selection and stall-until-resolved miss handling. Tag, valid, dirty, LRU and data storage are internal register arrays with combinational lookup.

## Interface
- ADDR_W, 32, byte-address width
- LINE_BYTES, 32, bytes per line (power of 2, ≥8); LINE_W = 8*LINE_BYTES bits
- SETS, 16, number of sets (power of 2, ≥2)
- Derived: OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W; index = addr[OFF_W+IDX_W-1:OFF_W]
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- p1_data_i  in  32  store data
- p1_addr_i  in  ADDR_W  byte address (addr[1:0] ignored)
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request (wins if both asserted)
- p1_data_o  out  32  load data, valid when request && !stall
- p1_stall_o  out  1  request not yet satisfied
- mem_data_i  in  LINE_W  fill data
- mem_ack_i  in  1  one-cycle transaction done
- mem_data_o  out  LINE_W  write-back line
- mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits 0)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write-back, 0 = fill

## Operation
- Lookup: hit = request && valid[w][idx] && tag[w][idx]==addr tag for either way.
- Read hit: p1_data_o = selected word addr[OFF_W-1:2], same cycle; otherwise p1_data_o = 0.
- Write hit: word written at the clock edge; dirty[w] set; no memory traffic.
- Any hit sets lru[idx] to the other way. lru[idx] always names the victim candidate.
- p1_stall_o = request && !hit, combinational. The CPU holds p1_* stable while stalled.
- Victim selection on a miss: invalid way0, else invalid way1, else way lru[idx].
- State machine: IDLE, WB, GAP, FILL.
  - IDLE with miss: if victim is valid && dirty, go to WB; else go to FILL. Victim way and miss address are latched.
  - WB: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, idx, 0}, mem_data_o=victim line. On mem_ack_i, go to GAP.
  - GAP: mem_enable_o=0 for exactly one cycle, then go to FILL.
  - FILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={miss tag, idx, 0}. On mem_ack_i, mem_data_i is written into the victim way (valid=1, dirty=0, tag updated), lru[idx] is set to the other way, and the state returns to IDLE.
  - The retried access then hits on the next cycle. A store miss completes as a write hit in that cycle.
- All mem_* outputs are registered.
- Reset values: state IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0. All valid, dirty and lru bits are 0. p1_stall_o=0 and p1_data_o=0 while no request is present.
- Reset mid-transaction: the state returns to IDLE at once and mem_enable_o drops. All lines are invalidated and dirty data is discarded.
- mem_ack_i outside WB/FILL is ignored.

## Timing
- Hit: 0 stall cycles.
- Clean miss, memory latency L cycles (ack L cycles after enable rises):
  - cycle 0: miss detected;
  - cycle 1: mem_enable_o rises;
  - cycle 1+L: ack;
  - cycle 2+L: hit, stall low.
- Dirty miss: the clean-miss timing plus WB duration plus 1 GAP cycle.
- mem_enable_o is never high in two consecutive transactions without a GAP or IDLE cycle between them.

## Test plan
Bench settings: SETS=16, LINE_BYTES=32 (index = addr[8:5], tag = addr[31:9]).

- Cold read miss: reset, read 0x00000004, mem returns word1=0xDEADBEEF with ack 3 cycles after enable. Required: FILL addr 0x00000000, mem_write_o=0, stall low the cycle after ack, p1_data_o=0xDEADBEEF.
- Set conflict without eviction: read 0x00000000 then 0x00000200. Required: second access fills way1 with no write-back; both re-reads then hit with 0 stall.
- Dirty LRU eviction: with 0x0 and 0x200 resident, write 0x11111111 to 0x00000008, read 0x200, then read 0x400. Required: WB to 0x00000000 with line word2=0x11111111, one GAP cycle with enable low, then FILL of 0x00000400 into the evicted way.
- Clean eviction: repeat the dirty-eviction sequence without the store. Required: no WB phase; FILL 0x00000400 starts the cycle after miss detection.
- Write miss allocate: write 0xA5A5A5A5 to 0x00001004. Required: FILL 0x00001000, then store completes. A later eviction of this line writes back word1=0xA5A5A5A5.
- Reset mid-FILL: assert rst_i during FILL. Required: mem_enable_o=0 immediately; a re-read of a previously resident address misses.
